// File: rtl/pulse_stretch_tx.sv
// rtl/pulse_stretch_tx.sv - event-to-stretched-pulse transmitter with pending-event counter
module pulse_stretch_tx #(
  parameter int HIGH_CYC = 3,
  parameter int GAP_CYC  = 3,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             ovf_clr,
  output logic             sig_out,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] PMAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [7:0]       HIGH_LD = 8'(HIGH_CYC - 1);
  localparam logic [7:0]       GAP_LD  = 8'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_phase;
  logic [7:0]       w_phase_nxt;
  logic [CNT_W-1:0] r_pend;
  logic [CNT_W-1:0] w_pend_nxt;
  logic             r_sig_out;
  logic             r_ovf;

  logic w_phase_last;
  logic w_pend_nz;
  logic w_launch;
  logic w_dec;
  logic w_direct;
  logic w_inc;
  logic w_drop;

  // Next-state, phase counter and pending-count decisions
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_pend_nxt   = r_pend;
    w_phase_last = (r_phase == 8'd0);
    w_pend_nz    = (r_pend != '0);

    // A new pulse may start from idle or on the final gap cycle, so
    // back-to-back pulses run at HIGH_CYC+GAP_CYC with no idle cycle.
    w_launch = ((r_state == IDLE) || ((r_state == GAP) && w_phase_last)) &&
               (sig_in || w_pend_nz);

    case (r_state)
      IDLE: begin
        w_phase_nxt = 8'd0;
      end
      HIGH: begin
        if (w_phase_last) begin
          w_state_nxt = GAP;
          w_phase_nxt = GAP_LD;
        end else begin
          w_phase_nxt = r_phase - 8'd1;
        end
      end
      GAP: begin
        if (w_phase_last) begin
          w_state_nxt = IDLE;
          w_phase_nxt = 8'd0;
        end else begin
          w_phase_nxt = r_phase - 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_phase_nxt = 8'd0;
      end
    endcase

    if (w_launch) begin
      w_state_nxt = HIGH;
      w_phase_nxt = HIGH_LD;
    end

    // Older queued events go first to keep pulses in order; a fresh
    // event is only sent directly when nothing is queued.
    w_dec    = w_launch && w_pend_nz;
    w_direct = w_launch && !w_pend_nz;
    w_inc    = sig_in && !w_direct;
    w_drop   = w_inc && !w_dec && (r_pend == PMAX);

    if (w_inc && !w_dec && !w_drop) begin
      w_pend_nxt = r_pend + CNT_ONE;
    end else if (w_dec && !w_inc) begin
      w_pend_nxt = r_pend - CNT_ONE;
    end
  end

  // FSM state and phase counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Registered pulse output, pending counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig_out <= 1'b0;
      r_pend    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_sig_out <= (w_state_nxt == HIGH);
      r_pend    <= w_pend_nxt;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign sig_out  = r_sig_out;
  assign busy     = (r_state != IDLE);
  assign pend_cnt = r_pend;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_pulse_stretch_tx.sv
// tb/tb_pulse_stretch_tx.sv - randomized and directed check of pulse_stretch_tx against a timing model
module tb_pulse_stretch_tx;

  localparam int PMAX = 15;

  logic       clk;
  logic       rst;
  logic       sig_in;
  logic       ovf_clr;
  logic       so   [2];
  logic       bsy  [2];
  logic [3:0] pc   [2];
  logic       ov   [2];

  int n_checks;
  int n_fail;
  int t;
  int peak;

  int mh      [2];
  int mg      [2];
  int m_pend  [2];
  int m_ovf   [2];
  int m_last  [2];
  int m_avail [2];

  pulse_stretch_tx #(.HIGH_CYC(3), .GAP_CYC(3), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .ovf_clr(ovf_clr),
    .sig_out(so[0]), .busy(bsy[0]), .pend_cnt(pc[0]), .ovf(ov[0])
  );

  pulse_stretch_tx #(.HIGH_CYC(1), .GAP_CYC(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .ovf_clr(ovf_clr),
    .sig_out(so[1]), .busy(bsy[1]), .pend_cnt(pc[1]), .ovf(ov[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: a pulse launched at cycle L is high during L+1..L+H and the
  // transmitter is busy through L+H+G; the next launch may be decided at L+H+G.
  task automatic model_reset(input int k);
    m_pend[k]  = 0;
    m_ovf[k]   = 0;
    m_last[k]  = -100000;
    m_avail[k] = t + 1;
  endtask

  task automatic model_step(input int k, input logic r, input logic s, input logic c);
    bit launch, dec, direct, inc, drop;
    if (r) begin
      model_reset(k);
    end else begin
      launch = (t >= m_avail[k]) && (s || m_pend[k] > 0);
      dec    = launch && m_pend[k] > 0;
      direct = launch && !dec;
      inc    = s && !direct;
      drop   = inc && !dec && m_pend[k] == PMAX;
      if (inc && !drop) m_pend[k]++;
      if (dec) m_pend[k]--;
      if (drop) m_ovf[k] = 1;
      else if (c) m_ovf[k] = 0;
      if (launch) begin
        m_last[k]  = t;
        m_avail[k] = t + mh[k] + mg[k];
      end
    end
  endtask

  task automatic run_cycle(input logic r, input logic s, input logic c);
    @(posedge clk);
    #1;
    rst     = r;
    sig_in  = s;
    ovf_clr = c;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_sig_out@%0d", k, t), 32'(so[k]),
          32'((t >= m_last[k] + 1) && (t <= m_last[k] + mh[k])));
      chk($sformatf("d%0d_busy@%0d", k, t), 32'(bsy[k]),
          32'((t >= m_last[k] + 1) && (t <= m_last[k] + mh[k] + mg[k])));
      chk($sformatf("d%0d_pend_cnt@%0d", k, t), 32'(pc[k]), 32'(m_pend[k]));
      chk($sformatf("d%0d_ovf@%0d", k, t), 32'(ov[k]), 32'(m_ovf[k]));
    end
    if (32'(pc[0]) > 32'(peak)) peak = int'(pc[0]);
    for (int k = 0; k < 2; k++) model_step(k, r, s, c);
    t++;
  endtask

  task automatic do_reset();
    run_cycle(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    t        = 0;
    peak     = 0;
    mh[0] = 3; mg[0] = 3;
    mh[1] = 1; mg[1] = 1;
    rst     = 1'b1;
    sig_in  = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 2; k++) model_reset(k);

    // Single event at relative cycle 10
    for (int i = 0; i < 24; i++) run_cycle(1'b0, i == 10, 1'b0);

    // Events at relative cycles 10 and 11
    do_reset();
    for (int i = 0; i < 26; i++) run_cycle(1'b0, i == 10 || i == 11, 1'b0);

    // Same scenario with reset at relative cycle 12
    do_reset();
    for (int i = 0; i < 30; i++) run_cycle(i == 12, i == 10 || i == 11, 1'b0);

    // Saturation: 40 cycles of sig_in, ovf_clr colliding with a drop, then drain
    do_reset();
    peak = 0;
    for (int i = 0; i < 50; i++) run_cycle(1'b0, i >= 10 && i < 50, i == 45);
    for (int i = 0; i < 110; i++) run_cycle(1'b0, 1'b0, i == 5);
    chk("d0_pend_peak", 32'(peak), 32'(PMAX));

    // Four consecutive events (exercises the 1/1 instance alternating pattern)
    do_reset();
    for (int i = 0; i < 30; i++) run_cycle(1'b0, i >= 10 && i <= 13, 1'b0);

    // Randomized traffic with occasional clears and resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      run_cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 45,
                $urandom_range(0, 99) < 5);
    end

    // Bursty random traffic to revisit saturation
    for (int i = 0; i < 300; i++) begin
      run_cycle(1'b0, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 3);
    end
    for (int i = 0; i < 120; i++) run_cycle(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
